// File: rtl/fc_s3_pkg.sv
// fc_s3_pkg: sizes, FSM states and per-class bias for the fc_s3 classifier
package fc_s3_pkg;
  localparam int N_IN = 144;
  localparam int N_CLASS = 4;
  localparam int W_IN = 35;
  localparam int W_W = 8;
  localparam int W_ACC = 51;
  typedef enum logic [1:0] {IDLE, MAC, CMP, DONE} state_t;
  localparam logic signed [W_ACC-1:0] FC_BIAS [N_CLASS-1:0] = '{default: '0};
endpackage

// File: rtl/fc_s3_weights_rom.sv
// fc_s3_weights_rom: combinational 8-bit signed weight table indexed by class and input index
module fc_s3_weights_rom
  import fc_s3_pkg::*;
(
  input  logic [1:0]            cls,
  input  logic [7:0]            idx,
  output logic signed [W_W-1:0] w
);
  assign w = $signed((8'(cls) * 8'd37 + idx * 8'd13 + (idx >> 3)) ^ 8'h5A);
endmodule

// File: rtl/fc_s3.sv
// fc_s3: sequential fully-connected layer, one MAC per cycle, then argmax over 4 classes
module fc_s3
  import fc_s3_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s2_done,
  input  logic signed [W_IN-1:0]   s2_In [N_IN-1:0],
  output logic                     busy,
  output logic                     result_valid,
  output logic [1:0]               class_idx,
  output logic signed [W_ACC-1:0]  score [N_CLASS-1:0]
);
  state_t state_q, state_d;
  logic [1:0] cls_q, cls_d, class_idx_q, class_idx_d, best;
  logic [7:0] idx_q, idx_d;
  logic signed [W_ACC-1:0] acc_q, acc_d, sum;
  logic signed [W_ACC-1:0] score_q [N_CLASS-1:0];
  logic signed [W_ACC-1:0] score_d [N_CLASS-1:0];
  logic signed [W_W-1:0] w;
  fc_s3_weights_rom u_rom (.cls(cls_q), .idx(idx_q), .w(w));
  assign sum = acc_q + W_ACC'(s2_In[idx_q]) * W_ACC'(w);
  // argmax with strict compare so the lowest index wins ties
  always_comb begin
    best = 2'd0;
    for (int c = 1; c < N_CLASS; c++) if (score_q[c] > score_q[best]) best = 2'(c);
  end
  // next state: start in IDLE, walk (class,index) in MAC, store each class on index wrap
  always_comb begin
    state_d = state_q;
    cls_d = cls_q;
    idx_d = idx_q;
    acc_d = acc_q;
    score_d = score_q;
    class_idx_d = class_idx_q;
    case (state_q)
      IDLE: if (s2_done) begin
        state_d = MAC;
        acc_d = FC_BIAS[0];
        cls_d = '0;
        idx_d = '0;
      end
      MAC: if (idx_q == 8'(N_IN - 1)) begin
        score_d[cls_q] = sum;
        acc_d = FC_BIAS[cls_q + 2'd1];
        cls_d = cls_q + 2'd1;
        idx_d = '0;
        if (cls_q == 2'(N_CLASS - 1)) state_d = CMP;
      end else begin
        acc_d = sum;
        idx_d = idx_q + 8'd1;
      end
      CMP: begin
        class_idx_d = best;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset clears everything including held results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cls_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      class_idx_q <= '0;
      score_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      class_idx_q <= class_idx_d;
      score_q <= score_d;
    end
  end
  assign busy = state_q != IDLE;
  assign result_valid = state_q == DONE;
  assign class_idx = class_idx_q;
  assign score = score_q;
endmodule

// File: doc/fc_s3.md
FC_S3 -- requirements
Module: fc_s3

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, port names as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 s2_done  input  1  start pulse from stage 2: s2_In is valid.
REQ-005 s2_In  input  35 x [143:0]  stage-2 feature vector, signed two's complement, held stable by upstream while busy=1.
REQ-006 busy  output  1  high from the cycle after start acceptance until the result_valid cycle inclusive.
REQ-007 result_valid  output  1  one-cycle pulse: class_idx and score are valid.
REQ-008 class_idx  output  2  index of the winning class.
REQ-009 score  output  51 x [3:0]  signed per-class accumulated score, registered.

Function
REQ-010 The block SHALL compute score[c] = FC_BIAS[c] + sum over i=0..143 of s2_In[i]*W[c][i] for c=0..3, with W being 8-bit signed weights.
REQ-011 Arithmetic SHALL be signed with a 51-bit accumulator; no saturation, since width covers the worst case |35b x 8b| x 144.
REQ-012 FSM states SHALL be IDLE, MAC, CMP and DONE.
REQ-013 IDLE to MAC SHALL occur on s2_done=1; the accumulator loads FC_BIAS[0], with class counter=0 and index counter=0.
REQ-014 MAC SHALL do one multiply-accumulate per cycle at (class counter, index counter).
- Index counter wraps 143 to 0.
- On wrap, the accumulator is stored to score[class], the class counter increments, and the accumulator reloads FC_BIAS[next class].
REQ-015 MAC to CMP SHALL occur after the MAC at class=3, index=143 (576 MAC cycles in total).
REQ-016 CMP (one cycle) SHALL register class_idx = argmax(score); on a tie, the lowest index wins.
REQ-017 DONE (one cycle) SHALL assert result_valid=1, then return to IDLE.
REQ-018 Latency SHALL be fixed:
- start accepted in cycle 0;
- MAC occupies cycles 1..576;
- CMP occupies cycle 577;
- result_valid=1 in cycle 578;
- busy=0 in cycle 579.
REQ-019 s2_done SHALL be ignored while not in IDLE.
REQ-020 s2_done asserted in the same cycle as DONE SHALL be ignored; a start is accepted only in IDLE.
REQ-021 score and class_idx SHALL hold their last values until the next run's CMP/MAC store overwrites them.
REQ-022 score[c] SHALL update only when class c completes; partial sums SHALL never appear on score.
REQ-023 Weight lookup SHALL be combinational from (class counter, index counter), so there is no extra pipeline cycle.

Reset
REQ-024 Reset SHALL have priority over all other inputs in every state.
REQ-025 On reset: state=IDLE; busy=0; result_valid=0; class_idx=0; score[*]=0; accumulator=0; both counters=0.
REQ-026 Reset mid-MAC SHALL abort the run with no result_valid pulse; the next s2_done starts a full 578-cycle run.

Structure
REQ-027 Package fc_s3_pkg SHALL hold:
- N_IN=144, N_CLASS=4, W_IN=35, W_W=8, W_ACC=51;
- the FSM state enum;
- FC_BIAS[3:0] (51-bit signed, default all zero).
REQ-028 Weights SHALL live in one sub-module, fc_s3_weights_rom: input class (2b) and index (8b), output a combinational 8-bit signed weight.
REQ-029 FSM, counters, MAC and argmax SHALL live in fc_s3.

Verification
REQ-030 All s2_In=0, s2_done pulse -> result_valid at cycle 578, score[*]=0, class_idx=0 (tie rule), busy high cycles 1..578.
REQ-031 s2_In[i]=i-72 -> each score equals the bench model computed from the ROM contents; class_idx equals the model argmax.
REQ-032 All s2_In=2^34-1 and all s2_In=-2^34 -> scores match the model exactly, with no wrap (width check).
REQ-033 Second s2_done at cycles 100 and 578 -> ignored: exactly one result_valid, and busy drops at cycle 579.
REQ-034 Reset at cycle 300 -> outputs zero next cycle with no result_valid; a new s2_done yields a correct result 578 cycles later.
REQ-035 Back-to-back runs: s2_done at cycle 579 with new data -> accepted, second result correct, and first scores held until overwritten.
